// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encoding and the header address width.
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int NUM_FIFOS = 3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_state_e;

endpackage

// File: rtl/router_fsm.sv
// Router packet-sequencing FSM: decodes the header address, steers loading of
// data/parity into the selected FIFO and stalls on full or non-empty FIFOs.
module router_fsm #(
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              fifo_full,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);
  import router_pkg::*;

  router_state_e     state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;

  logic hdr_valid;
  logic hdr_empty;
  logic sel_empty;
  logic sel_soft_reset;

  // Address 3 (and anything wider) selects no FIFO, so its flags read as 0.
  function automatic logic pick(input logic [ADDR_W-1:0] idx,
                                input logic f0, input logic f1, input logic f2);
    logic r;
    r = 1'b0;
    if (idx == ADDR_W'(0))      r = f0;
    else if (idx == ADDR_W'(1)) r = f1;
    else if (idx == ADDR_W'(2)) r = f2;
    return r;
  endfunction

  always_comb begin
    hdr_valid      = (data_in < ADDR_W'(NUM_FIFOS));
    hdr_empty      = pick(data_in,  fifo_empty_0, fifo_empty_1, fifo_empty_2);
    sel_empty      = pick(addr_reg, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    sel_soft_reset = pick(addr_reg, soft_reset_0, soft_reset_1, soft_reset_2);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= DECODE_ADDRESS;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE_ADDRESS && pkt_valid)
        addr_reg <= data_in;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DECODE_ADDRESS:
        if (pkt_valid && hdr_valid)
          state_next = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:
        state_next = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       state_next = FIFO_FULL_STATE;
        else if (!pkt_valid) state_next = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) state_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        state_next = DECODE_ADDRESS;
        else if (low_pkt_valid) state_next = LOAD_PARITY;
        else                    state_next = LOAD_DATA;
      LOAD_PARITY:
        state_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:
        if (sel_empty) state_next = LOAD_FIRST_DATA;
      default:
        state_next = DECODE_ADDRESS;
    endcase
    // A timeout on the FIFO this packet targets abandons the packet.
    if (sel_soft_reset)
      state_next = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (state_reg == DECODE_ADDRESS);
    lfd_state     = (state_reg == LOAD_FIRST_DATA);
    ld_state      = (state_reg == LOAD_DATA);
    laf_state     = (state_reg == LOAD_AFTER_FULL);
    full_state    = (state_reg == FIFO_FULL_STATE);
    rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
    write_enb_reg = (state_reg == LOAD_DATA) || (state_reg == LOAD_PARITY) ||
                    (state_reg == LOAD_AFTER_FULL);
    busy          = !((state_reg == DECODE_ADDRESS) || (state_reg == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm with a packet-phase reference model checked every cycle.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       fifo_full;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  router_fsm #(.ADDR_W(2)) dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .fifo_full(fifo_full),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  // Packet phases of the model, named independently of the DUT encoding.
  localparam int P_IDLE = 0, P_FIRST = 1, P_BODY = 2, P_STALL = 3,
                 P_RESUME = 4, P_PARITY = 5, P_CHECK = 6, P_WAIT = 7;

  int m_phase = P_IDLE;
  int m_addr  = 0;

  // Output vector order: {detect,lfd,ld,laf,full,wen,rst_int,busy}
  localparam logic [7:0] O_IDLE   = 8'b1000_0000;
  localparam logic [7:0] O_FIRST  = 8'b0100_0001;
  localparam logic [7:0] O_BODY   = 8'b0010_0100;
  localparam logic [7:0] O_STALL  = 8'b0000_1001;
  localparam logic [7:0] O_RESUME = 8'b0001_0101;
  localparam logic [7:0] O_PARITY = 8'b0000_0101;
  localparam logic [7:0] O_CHECK  = 8'b0000_0011;
  localparam logic [7:0] O_WAIT   = 8'b0000_0001;

  function automatic logic [7:0] phase_outs(input int p);
    logic [7:0] tbl [8];
    tbl = '{O_IDLE, O_FIRST, O_BODY, O_STALL, O_RESUME, O_PARITY, O_CHECK, O_WAIT};
    return tbl[p];
  endfunction

  function automatic logic flag_of(input int a, input logic f0, input logic f1, input logic f2);
    if (a == 0) return f0;
    if (a == 1) return f1;
    if (a == 2) return f2;
    return 1'b0;
  endfunction

  function automatic int phase_after(input int p, input int a);
    int n;
    n = p;
    if (p == P_IDLE && pkt_valid && data_in != 2'd3)
      n = flag_of(int'(data_in), fifo_empty_0, fifo_empty_1, fifo_empty_2) ? P_FIRST : P_WAIT;
    else if (p == P_FIRST)  n = P_BODY;
    else if (p == P_BODY)   n = fifo_full ? P_STALL : (pkt_valid ? P_BODY : P_PARITY);
    else if (p == P_STALL)  n = fifo_full ? P_STALL : P_RESUME;
    else if (p == P_RESUME) n = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_BODY);
    else if (p == P_PARITY) n = P_CHECK;
    else if (p == P_CHECK)  n = fifo_full ? P_STALL : P_IDLE;
    else if (p == P_WAIT && flag_of(a, fifo_empty_0, fifo_empty_1, fifo_empty_2)) n = P_FIRST;
    if (flag_of(a, soft_reset_0, soft_reset_1, soft_reset_2)) n = P_IDLE;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_phase <= P_IDLE;
      m_addr  <= 0;
    end else begin
      m_phase <= phase_after(m_phase, m_addr);
      if (m_phase == P_IDLE && pkt_valid) m_addr <= int'(data_in);
    end
  end

  function automatic logic [7:0] dut_outs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end else
      $display("ok   %s @%0t: outs %b", name, $time, act);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model", dut_outs(), phase_outs(m_phase));
      check("onehot", 8'($countones({detect_add, lfd_state, ld_state, laf_state,
                                     full_state, rst_int_reg}) <= 1), 8'd1);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    fifo_full = 1'b0; soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    check("reset", dut_outs(), 8'b1000_0000);
    resetn = 1'b1;

    // Header to FIFO 1, body, then parity and back to idle
    pkt_valid = 1'b1; data_in = 2'd1;
    cyc(); check("hdr_lfd", dut_outs(), 8'b0100_0001);
    cyc(); check("load_data", dut_outs(), 8'b0010_0100);
    pkt_valid = 1'b0;
    cyc(); check("load_parity", dut_outs(), 8'b0000_0101);
    cyc(); check("check_parity", dut_outs(), 8'b0000_0011);
    cyc(); check("back_decode", dut_outs(), 8'b1000_0000);

    // Stall on full for three cycles, resume with low_pkt_valid
    pkt_valid = 1'b1; data_in = 2'd1;
    cyc(); cyc();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); check("full_stall", dut_outs(), 8'b0000_1001);
    end
    fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    cyc(); check("after_full", dut_outs(), 8'b0001_0101);
    cyc(); check("laf_to_parity", dut_outs(), 8'b0000_0101);
    low_pkt_valid = 1'b0; fifo_full = 1'b1;
    cyc(); check("chk_par_full", dut_outs(), 8'b0000_0011);
    cyc(); check("chk_to_full", dut_outs(), 8'b0000_1001);
    fifo_full = 1'b0; parity_done = 1'b1;
    cyc(); check("laf_parity_done", dut_outs(), 8'b0001_0101);
    cyc(); check("laf_to_decode", dut_outs(), 8'b1000_0000);
    parity_done = 1'b0;

    // Non-empty FIFO 2: wait, then load once drained
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    cyc(); check("wait_empty", dut_outs(), 8'b0000_0001);
    pkt_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); check("wait_hold", dut_outs(), 8'b0000_0001);
    end
    fifo_empty_2 = 1'b1;
    cyc(); check("wait_to_lfd", dut_outs(), 8'b0100_0001);
    cyc(); cyc(); cyc(); cyc();
    check("wait_pkt_done", dut_outs(), 8'b1000_0000);

    // Soft reset: only the selected FIFO's timeout counts
    pkt_valid = 1'b1; data_in = 2'd0;
    cyc(); cyc();
    soft_reset_1 = 1'b1;
    cyc(); check("soft_rst_other", dut_outs(), 8'b0010_0100);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1; pkt_valid = 1'b0;
    cyc(); check("soft_rst_sel", dut_outs(), 8'b1000_0000);
    soft_reset_0 = 1'b0;

    // Invalid header address stays in decode
    pkt_valid = 1'b1; data_in = 2'd3;
    cyc(); check("hdr_invalid", dut_outs(), 8'b1000_0000);
    cyc(); check("hdr_invalid2", dut_outs(), 8'b1000_0000);

    // Hard reset mid-stall, then prove addr returned to 0
    data_in = 2'd1;
    cyc(); cyc();
    fifo_full = 1'b1;
    cyc(); check("pre_reset_full", dut_outs(), 8'b0000_1001);
    resetn = 1'b0;
    cyc(); check("reset_in_full", dut_outs(), 8'b1000_0000);
    resetn = 1'b1; fifo_full = 1'b0; soft_reset_0 = 1'b1;
    cyc(); check("addr_zero_after_rst", dut_outs(), 8'b1000_0000);
    soft_reset_0 = 1'b0;
    cyc(); check("hdr_after_rst", dut_outs(), 8'b0100_0001);
    pkt_valid = 1'b0;
    cyc(); cyc(); cyc(); cyc();

    // Background traffic, checked only by the model
    for (int i = 0; i < 300; i++) begin
      pkt_valid     = 1'($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_empty_0  = 1'($urandom_range(0, 1));
      fifo_empty_1  = 1'($urandom_range(0, 1));
      fifo_empty_2  = 1'($urandom_range(0, 1));
      fifo_full     = 1'($urandom_range(0, 3) == 0);
      soft_reset_0  = 1'($urandom_range(0, 15) == 0);
      soft_reset_1  = 1'($urandom_range(0, 15) == 0);
      soft_reset_2  = 1'($urandom_range(0, 15) == 0);
      parity_done   = 1'($urandom_range(0, 3) == 0);
      low_pkt_valid = 1'($urandom_range(0, 1));
      cyc();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
